cdiv: RTL and testbench

Sequential custom-float divider: the inverse operation to the `cmult` multiplier, sharing its `EXP`/`FRA` format, its `aresetn`/`valid` conventions and its 3-bit `flag` encoding. It computes `Y = A / B` by restoring division on the significands, one quotient bit per clock, then rounds to nearest-even. It sits beside `cmult` in the math datapath and serves normalisation and scaling stages that need a quotient.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/cdiv_mant.sv | 61 ++++++
 rtl/cdiv.sv | 214 +++++++++++++++++++++
 tb/tb_cdiv.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Definitions shared by the custom-float datapath blocks: bias, flag bit positions,
// sequencer states and special-value constructors.
package fp_pkg;

    localparam int FLAG_UF = 0;
    localparam int FLAG_OV = 1;
    localparam int FLAG_NV = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_ROUND
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } spec_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Constructors return a 64-bit word; callers size-cast down to their own format.
    function automatic logic [63:0] fp_inf(input int exp_w, input int fra_w, input logic sign);
        return (64'(sign) << (exp_w + fra_w)) | (((64'd1 << exp_w) - 64'd1) << fra_w);
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int fra_w);
        return (((64'd1 << exp_w) - 64'd1) << fra_w) | (64'd1 << (fra_w - 1));
    endfunction

    function automatic logic [63:0] fp_zero(input int exp_w, input int fra_w, input logic sign);
        return 64'(sign) << (exp_w + fra_w);
    endfunction

endpackage

// File: rtl/cdiv_mant.sv
// Iterative restoring divider on (FRA+1)-bit significands; one quotient bit per clock,
// FRA+3 bits total (integer, fraction, guard, round) plus a sticky from the remainder.
module cdiv_mant
    import fp_pkg::*;
#(
    parameter int FRA = 10
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic           start,
    input  logic [FRA:0]   ma,
    input  logic [FRA:0]   mb,
    output logic           done,
    output logic [FRA+2:0] q,
    output logic           sticky
);

    localparam int N  = FRA + 3;
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0]  r_cnt;
    logic [FRA+1:0] r_rem;
    logic [FRA:0]   r_div;
    logic [FRA+2:0] r_q;

    logic           w_ge;
    logic [FRA+1:0] w_diff;
    logic [FRA+1:0] w_next;

    assign w_ge   = r_rem >= {1'b0, r_div};
    assign w_diff = r_rem - {1'b0, r_div};
    assign w_next = w_ge ? w_diff : r_rem;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CW'(N);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // The partial remainder stays below the divisor, so the doubled value always fits.
    always_ff @(posedge clk) begin
        if (start) begin
            r_rem <= {1'b0, ma};
            r_div <= mb;
            r_q   <= '0;
        end else if (r_cnt != '0) begin
            r_rem <= w_next << 1;
            r_q   <= {r_q[FRA+1:0], w_ge};
        end
    end

    // High while the final quotient bit resolves on the coming edge.
    assign done   = (r_cnt == CW'(1));
    assign q      = r_q;
    assign sticky = |r_rem;

endmodule

// File: rtl/cdiv.sv
// Sequential custom-float divider Y = A / B: unpack and special-case in PREP, restoring
// significand division in DIV, normalise and round-to-nearest-even in ROUND.
module cdiv
    import fp_pkg::*;
#(
    parameter int EXP = 5,
    parameter int FRA = 10
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               valid,
    input  logic [EXP+FRA:0]   A,
    input  logic [EXP+FRA:0]   B,
    output logic               in_ready,
    output logic               out_valid,
    output logic [EXP+FRA:0]   Y,
    output logic [2:0]         flag
);

    localparam int W  = EXP + FRA + 1;
    localparam int EW = EXP + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'(fp_bias(EXP));
    localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP) - 1);
    localparam logic signed [EW-1:0] EONE  = EW'(1);
    localparam logic signed [EW-1:0] EZERO = '0;

    function automatic logic rne_up(input logic g, input logic r, input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    function automatic logic [2:0] flag_of(input int idx);
        logic [2:0] f;
        f      = '0;
        f[idx] = 1'b1;
        return f;
    endfunction

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [W-1:0]           r_y;
    logic [2:0]             r_flag;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    spec_t                  r_spec;
    logic                   r_sign;
    logic signed [EW-1:0]   r_exp;

    logic                   w_sa, w_sb;
    logic [EXP-1:0]         w_ea, w_eb;
    logic [FRA-1:0]         w_fa, w_fb;
    logic                   w_a_zero, w_a_inf, w_a_nan;
    logic                   w_b_zero, w_b_inf, w_b_nan;
    spec_t                  w_spec;
    logic signed [EW-1:0]   w_e_prep;
    logic                   w_start;
    logic                   w_done;
    logic [FRA+2:0]         w_q;
    logic                   w_sticky;

    assign {w_sa, w_ea, w_fa} = r_a;
    assign {w_sb, w_eb, w_fb} = r_b;

    // Subnormals are treated as zero: only the exponent field decides zero-ness.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (&w_ea) && (w_fa == '0);
    assign w_b_inf  = (&w_eb) && (w_fb == '0);
    assign w_a_nan  = (&w_ea) && (w_fa != '0);
    assign w_b_nan  = (&w_eb) && (w_fb != '0);

    always_comb begin
        w_spec = SP_NONE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec = SP_NAN;
        end else if (w_b_zero || w_a_inf) begin
            w_spec = SP_INF;
        end else if (w_a_zero || w_b_inf) begin
            w_spec = SP_ZERO;
        end
    end

    assign w_e_prep = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS;
    assign w_start  = (r_state == ST_PREP);

    cdiv_mant #(
        .FRA(FRA)
    ) u_mant (
        .clk    (clk),
        .aresetn(aresetn),
        .start  (w_start),
        .ma     ({1'b1, w_fa}),
        .mb     ({1'b1, w_fb}),
        .done   (w_done),
        .q      (w_q),
        .sticky (w_sticky)
    );

    logic [FRA:0]           w_mant;
    logic                   w_g, w_r, w_up;
    logic signed [EW-1:0]   w_e_n, w_e_r;
    logic [FRA+1:0]         w_mant_r;
    logic [FRA-1:0]         w_frac;
    logic [W-1:0]           w_y;
    logic [2:0]             w_flag;

    always_comb begin
        if (w_q[FRA+2]) begin
            w_mant = w_q[FRA+2:2];
            w_g    = w_q[1];
            w_r    = w_q[0];
            w_e_n  = r_exp;
        end else begin
            w_mant = w_q[FRA+1:1];
            w_g    = w_q[0];
            w_r    = 1'b0;
            w_e_n  = r_exp - EONE;
        end
        w_up     = rne_up(w_g, w_r, w_sticky, w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {{(FRA+1){1'b0}}, w_up};
        if (w_mant_r[FRA+1]) begin
            w_e_r  = w_e_n + EONE;
            w_frac = w_mant_r[FRA:1];
        end else begin
            w_e_r  = w_e_n;
            w_frac = w_mant_r[FRA-1:0];
        end
    end

    always_comb begin
        w_y    = {r_sign, w_e_r[EXP-1:0], w_frac};
        w_flag = '0;
        case (r_spec)
            SP_NAN: begin
                w_y    = W'(fp_qnan(EXP, FRA));
                w_flag = flag_of(FLAG_NV);
            end
            SP_INF: begin
                w_y    = W'(fp_inf(EXP, FRA, r_sign));
                w_flag = flag_of(FLAG_OV);
            end
            SP_ZERO: begin
                w_y    = W'(fp_zero(EXP, FRA, r_sign));
                w_flag = flag_of(FLAG_UF);
            end
            default: begin
                if (w_e_r >= EMAX) begin
                    w_y    = W'(fp_inf(EXP, FRA, r_sign));
                    w_flag = flag_of(FLAG_OV);
                end else if (w_e_r <= EZERO) begin
                    w_y    = W'(fp_zero(EXP, FRA, r_sign));
                    w_flag = flag_of(FLAG_UF);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (valid && r_in_ready) begin
            r_a <= A;
            r_b <= B;
        end
        if (r_state == ST_PREP) begin
            r_spec <= w_spec;
            r_sign <= w_sa ^ w_sb;
            r_exp  <= w_e_prep;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flag      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_state    <= ST_PREP;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_state <= ST_DIV;
                end
                ST_DIV: begin
                    if (w_done) begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_y         <= w_y;
                    r_flag      <= w_flag;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Y         = r_y;
    assign flag      = r_flag;

endmodule

// File: tb/tb_cdiv.sv
// Self-checking bench for cdiv: directed corner cases plus random operands checked
// against an exact-arithmetic division model.
module tb_cdiv;

    localparam int EXP = 5;
    localparam int FRA = 10;
    localparam int W   = EXP + FRA + 1;
    localparam int LAT = FRA + 5;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] Y;
    logic [2:0]   flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cdiv #(.EXP(EXP), .FRA(FRA)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .valid    (valid),
        .A        (A),
        .B        (B),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .Y        (Y),
        .flag     (flag)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact quotient of the significands, rounded to nearest-even on the true remainder.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] y, output logic [2:0] f);
        int ea, eb, fa, fb, e;
        longint ma, mb, num, q, r;
        bit s, az, bz, ai, bi, an, bn;
        s  = a[W-1] ^ b[W-1];
        ea = int'(a[W-2:FRA]); fa = int'(a[FRA-1:0]);
        eb = int'(b[W-2:FRA]); fb = int'(b[FRA-1:0]);
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
        an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
        if (an || bn || (az && bz) || (ai && bi)) begin
            y = 16'h7E00; f = 3'b100;
        end else if (bz || ai) begin
            y = {s, 15'h7C00}; f = 3'b010;
        end else if (az || bi) begin
            y = {s, 15'h0000}; f = 3'b001;
        end else begin
            ma = 1024 + fa;
            mb = 1024 + fb;
            e  = ea - eb + 15;
            if (ma < mb) begin
                e--;
                num = ma << 11;
            end else begin
                num = ma << 10;
            end
            q = num / mb;
            r = num % mb;
            if ((2 * r > mb) || ((2 * r == mb) && (q % 2 == 1))) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
            if (e >= 31) begin
                y = {s, 15'h7C00}; f = 3'b010;
            end else if (e <= 0) begin
                y = {s, 15'h0000}; f = 3'b001;
            end else begin
                y = {s, 5'(e), 10'(q)}; f = 3'b000;
            end
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic wait_result(input int n0, output logic [W-1:0] y, output logic [2:0] f,
                               output int lat);
        int n = n0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = out_valid ? n : -1;
        y = Y;
        f = flag;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ey, input logic [2:0] ef);
        logic [W-1:0] y;
        logic [2:0]   f;
        int           lat;
        start_op(a, b);
        wait_result(0, y, f, lat);
        check({tag, "_Y"}, 32'(y), 32'(ey));
        check({tag, "_flag"}, 32'(f), 32'(ef));
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
    endtask

    function automatic logic [W-1:0] gen_operand();
        logic       s;
        logic [4:0] e;
        logic [9:0] m;
        int         k;
        s = 1'($urandom);
        m = 10'($urandom);
        k = int'($urandom_range(0, 11));
        case (k)
            0:       e = 5'd0;
            1:       begin e = 5'd31; m = '0; end
            2:       begin e = 5'd31; m[9] = 1'b1; end
            3:       e = 5'd0;
            4:       e = 5'(1 + $urandom_range(0, 2));
            5:       e = 5'(28 + $urandom_range(0, 2));
            default: e = 5'(1 + $urandom_range(0, 29));
        endcase
        return {s, e, m};
    endfunction

    initial begin
        logic [W-1:0] y, ry, a, b;
        logic [2:0]   f, rf;
        int           lat, pulses;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_Y", 32'(Y), 32'd0);
        check("reset_flag", 32'(flag), 32'd0);
        aresetn = 1'b1;
        @(negedge clk);

        directed("unit", 16'h2E66, 16'h2E66, 16'h3C00, 3'b000);

        start_op(16'h3C00, 16'h4200);
        wait_result(0, y, f, lat);
        check("third_Y", 32'(y), 32'h3555);
        check("third_latency", 32'(lat), 32'(LAT));
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        start_op(16'h4000, 16'h3C00);
        wait_result(0, y, f, lat);
        check("b2b_Y", 32'(y), 32'h4000);
        check("b2b_flag", 32'(f), 32'd0);
        check("b2b_latency", 32'(lat), 32'(LAT));

        directed("div0", 16'h3C00, 16'h0000, 16'h7C00, 3'b010);
        directed("zero_zero", 16'h0000, 16'h0000, 16'h7E00, 3'b100);
        directed("negzero", 16'h8000, 16'h4000, 16'h8000, 3'b001);
        directed("overflow", 16'h7BFF, 16'h3800, 16'h7C00, 3'b010);
        directed("flush", 16'h0400, 16'h4000, 16'h0000, 3'b001);
        directed("inf_inf", 16'hFC00, 16'h7C00, 16'h7E00, 3'b100);
        directed("fin_inf", 16'hC000, 16'h7C00, 16'h8000, 3'b001);

        start_op(16'h3C00, 16'h4200);
        repeat (4) @(negedge clk);
        valid = 1'b1;
        A = 16'h4000;
        B = 16'h3C00;
        @(negedge clk);
        valid = 1'b0;
        wait_result(5, y, f, lat);
        check("busy_valid_Y", 32'(y), 32'h3555);
        check("busy_valid_latency", 32'(lat), 32'(LAT));
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("busy_valid_no_extra", 32'(pulses), 32'd0);

        start_op(16'h2E66, 16'h2E66);
        repeat (6) @(negedge clk);
        aresetn = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_Y", 32'(Y), 32'd0);
        check("midreset_flag", 32'(flag), 32'd0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midreset_no_result", 32'(pulses), 32'd0);
        directed("after_reset", 16'h4000, 16'h3C00, 16'h4000, 3'b000);

        for (int i = 0; i < 60; i++) begin
            a = gen_operand();
            b = gen_operand();
            ref_div(a, b, ry, rf);
            start_op(a, b);
            wait_result(0, y, f, lat);
            check("rand_Y", 32'(y), 32'(ry));
            check("rand_flag", 32'(f), 32'(rf));
            check("rand_latency", 32'(lat), 32'(LAT));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
